// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding instruction memory request and fills the
// IF/ID pipeline register, handling load-use stalls and branch redirects with squash.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pipeline,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        StRun,
        StDrop,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] target_aligned;
    logic [31:0] fetch_pc_plus4;

    assign target_aligned = {branch_target[31:2], 2'b00};
    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    // HOLD parks a fetched word, so no new request may be issued until it drains.
    assign imem_req       = !rst && (state_q != StHold);
    assign imem_addr      = fetch_pc_q;
    assign IF_ID_instr    = if_id_instr_q;
    assign IF_ID_pc_plus4 = if_id_pc_plus4_q;
    assign IF_ID_valid    = if_id_valid_q;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        redirect_pc_d    = redirect_pc_q;
        hold_instr_d     = hold_instr_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    if_id_valid_d = 1'b0;
                    if (imem_ack) begin
                        fetch_pc_d = target_aligned;
                    end else begin
                        // Request still in flight: remember the target, drop the stale reply.
                        redirect_pc_d = target_aligned;
                        state_d       = StDrop;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_plus4;
                    if (stall_pipeline) begin
                        hold_instr_d = imem_rdata;
                        state_d      = StHold;
                    end else begin
                        if_id_instr_d    = imem_rdata;
                        if_id_pc_plus4_d = fetch_pc_plus4;
                        if_id_valid_d    = 1'b1;
                    end
                end else if (!stall_pipeline) begin
                    if_id_valid_d = 1'b0;
                end
            end
            StDrop: begin
                if_id_valid_d = 1'b0;
                if (branch_taken) begin
                    redirect_pc_d = target_aligned;
                end
                if (imem_ack) begin
                    fetch_pc_d = branch_taken ? target_aligned : redirect_pc_q;
                    state_d    = StRun;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    if_id_valid_d = 1'b0;
                    fetch_pc_d    = target_aligned;
                    state_d       = StRun;
                end else if (!stall_pipeline) begin
                    // fetch_pc already advanced past the parked word.
                    if_id_instr_d    = hold_instr_q;
                    if_id_pc_plus4_d = fetch_pc_q;
                    if_id_valid_d    = 1'b1;
                    state_d          = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StRun;
            fetch_pc_q       <= RESET_PC;
            redirect_pc_q    <= 32'h0;
            hold_instr_q     <= 32'h0;
            if_id_instr_q    <= 32'h0;
            if_id_pc_plus4_q <= 32'h0;
            if_id_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            redirect_pc_q    <= redirect_pc_d;
            hold_instr_q     <= hold_instr_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port stall_pipeline, input, 1 bit, load-use stall from the hazard detection unit; holds the IF/ID register.
REQ-005 The block SHALL have port branch_taken, input, 1 bit, redirect-and-flush request from a later stage.
REQ-006 The block SHALL have port branch_target, input, 32 bits, redirect address, sampled only when branch_taken=1.
REQ-007 The block SHALL have port imem_req, output, 1 bit, instruction memory request valid.
REQ-008 The block SHALL have port imem_addr, output, 32 bits, instruction memory address.
REQ-009 The block SHALL have port imem_ack, input, 1 bit, one-cycle response strobe; imem_rdata is valid only in that cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits, fetched instruction.
REQ-011 The block SHALL have ports IF_ID_instr (32), IF_ID_pc_plus4 (32) and IF_ID_valid (1), all outputs, registered IF/ID pipeline contents.

Function
REQ-012 The block SHALL keep registers fetch_pc, redirect_pc and hold_instr, plus a 3-state FSM: RUN, DROP, HOLD.
REQ-013 The block SHALL drive imem_addr = fetch_pc at all times; imem_req=1 in RUN and DROP, 0 in HOLD and while rst=1.
REQ-014 The block SHALL hold imem_req and imem_addr stable from request until the imem_ack cycle; at most one request outstanding; ack allowed in the request cycle (zero wait).
REQ-015 The block SHALL compute all PC increments as +4 modulo 2^32 (wrap from FFFFFFFC to 00000000) and SHALL force branch_target[1:0] to 00.
REQ-016 The block SHALL give branch_taken priority over stall_pipeline in every state; on branch_taken it SHALL set IF_ID_valid<=0 next cycle.
REQ-017 RUN, branch_taken=1, imem_ack=1: fetch_pc<=branch_target, rdata discarded, stay RUN.
REQ-018 RUN, branch_taken=1, imem_ack=0: redirect_pc<=branch_target, go DROP.
REQ-019 RUN, imem_ack=1, no stall: IF_ID_instr<=imem_rdata, IF_ID_pc_plus4<=fetch_pc+4, IF_ID_valid<=1, fetch_pc<=fetch_pc+4.
REQ-020 RUN, imem_ack=1, stall: hold_instr<=imem_rdata, fetch_pc<=fetch_pc+4, IF/ID unchanged, go HOLD.
REQ-021 RUN, imem_ack=0, no stall: IF_ID_valid<=0 (bubble), IF_ID_instr/pc_plus4 unchanged; with stall: IF/ID unchanged.
REQ-022 DROP: IF_ID_valid held 0; branch_taken=1 SHALL overwrite redirect_pc (latest wins); on imem_ack: rdata discarded, fetch_pc<=redirect_pc (or branch_target if branch_taken same cycle), go RUN.
REQ-023 HOLD, branch_taken=1: hold_instr discarded, fetch_pc<=branch_target, go RUN.
REQ-024 HOLD, no branch, no stall: IF_ID_instr<=hold_instr, IF_ID_pc_plus4<=fetch_pc, IF_ID_valid<=1, go RUN; with stall: stay HOLD, all unchanged.
REQ-025 Latency: zero-wait memory with no stall SHALL deliver one valid IF/ID instruction per cycle, first valid IF_ID_valid in the 2nd cycle after rst deasserts.

Reset
REQ-026 While rst=1 at a clock edge: state<=RUN, fetch_pc<=RESET_PC, redirect_pc, hold_instr, IF_ID_instr, IF_ID_pc_plus4 <=0, IF_ID_valid<=0.
REQ-027 Reset SHALL abandon any outstanding memory request; the memory model is reset concurrently and never acks a pre-reset request.

Verification
REQ-028 Zero-wait memory returning addr as data, no stall -> IF_ID_instr 0,4,8,... IF_ID_pc_plus4 4,8,12,..., IF_ID_valid constantly 1 after first.
REQ-029 Memory with 2-cycle ack latency -> imem_addr stable across wait, IF_ID_valid pattern 0,0,1 repeating, no skipped address.
REQ-030 stall_pipeline=1 for 3 cycles while ack arrives -> IF/ID frozen, imem_req=0 in HOLD, buffered instr appears the cycle after stall drops, next fetch at +4.
REQ-031 branch_taken with target 32'h00000103 while ack pending in 3 cycles -> DROP, IF_ID_valid=0, stale rdata discarded, next imem_addr=32'h00000100.
REQ-032 branch_taken and stall_pipeline both 1 in HOLD -> hold_instr dropped, IF_ID_valid=0, fetch restarts at target.
REQ-033 rst asserted mid-wait in DROP -> next cycle imem_addr=RESET_PC, IF_ID_valid=0, state RUN.
